seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU that works on CHUNK bits per clock, LSB chunk first.
//
// Parameters
//   WIDTH     operand/result width (>= 2)
//   CHUNK     bits processed per cycle; must divide WIDTH (N = WIDTH/CHUNK)
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  a/b/op valid; accepted when in_valid && in_ready
//   in_ready  high only in IDLE
//   a, b      operands
//   op        000 AND, 001 OR, 010 XOR, 011 NOT a, 100 ADD, 101 SUB, 110 pass a, 111 pass b
//   out       result, stable while out_valid
//   out_valid high only in DONE; result leaves when out_valid && out_ready
//   out_ready consumer accepts the result; ignored outside DONE
//   carry     final carry-out for ADD/SUB (SUB: 1 = no borrow), else 0
//   zr, ng    out == 0, out[WIDTH-1]
//   state_dbg current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshake: both sides use valid/ready; a transfer happens on the rising
// edge where valid and ready are both 1. in_ready and out_valid are never
// high together, so one operation occupies the block from accept to release.
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             carry,
    output logic             zr,
    output logic             ng,
    output logic [1:0]       state_dbg
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_PASA = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, out_q, out_d;
    logic [2:0]       op_q;
    logic             c_q, c_d;
    logic [CHUNK-1:0] a_ch, b_ch, b_eff, res_ch;
    logic [CHUNK:0]   sum;
    logic             last, arith;

    assign last  = (cnt_q == CW'(N - 1));
    assign arith = (op_q == OP_ADD) || (op_q == OP_SUB);

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = BUSY;
            end
            BUSY: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // One chunk of the datapath: select chunk cnt_q, compute, merge back.
    always_comb begin
        a_ch = '0;
        b_ch = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_q == CW'(i)) begin
                a_ch = a_q[i*CHUNK +: CHUNK];
                b_ch = b_q[i*CHUNK +: CHUNK];
            end
        end
        // SUB is a + ~b + 1; the +1 comes from carry preset at accept.
        b_eff = (op_q == OP_SUB) ? ~b_ch : b_ch;
        sum   = {1'b0, a_ch} + {1'b0, b_eff} + {{CHUNK{1'b0}}, c_q};
        case (op_q)
            OP_AND:  res_ch = a_ch & b_ch;
            OP_OR:   res_ch = a_ch | b_ch;
            OP_XOR:  res_ch = a_ch ^ b_ch;
            OP_NOT:  res_ch = ~a_ch;
            OP_ADD,
            OP_SUB:  res_ch = sum[CHUNK-1:0];
            OP_PASA: res_ch = a_ch;
            default: res_ch = b_ch;
        endcase
        c_d   = arith ? sum[CHUNK] : 1'b0;
        out_d = out_q;
        for (int i = 0; i < N; i++) begin
            if (cnt_q == CW'(i)) out_d[i*CHUNK +: CHUNK] = res_ch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            out_q <= '0;
            c_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= op;
                        cnt_q <= '0;
                        out_q <= '0;
                        c_q   <= (op == OP_SUB);
                    end
                end
                BUSY: begin
                    out_q <= out_d;
                    c_q   <= c_d;
                    cnt_q <= last ? '0 : cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out       = out_q;
    assign carry     = c_q;
    assign zr        = (out_q == '0);
    assign ng        = out_q[WIDTH-1];
    assign state_dbg = state_q;

endmodule
